// File: rtl/trax_link_pkg.sv
// trax_link_pkg: definitions shared by the turn controller and the tranceiver
// link blocks.
//   MOVE_W        width of one move word on the link
//   link_state_t  turn-sequencer state encoding
//   WHITE/BLACK   colour constants (WHITE moves first)
//   timer_width   width of the shared guard/timeout down-counter
package trax_link_pkg;

  localparam int MOVE_W = 22;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_LOCAL   = 3'd1,
    S_GUARD   = 3'd2,
    S_REMOTE  = 3'd3,
    S_DELIVER = 3'd4,
    S_FAULT   = 3'd5
  } link_state_t;

  // Counter width for the larger of the two intervals. The counter only ever
  // holds (interval - 1), so $clog2 of the interval is enough. A width of at
  // least 1 is kept so that intervals of 1 or 2 still give a legal vector.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/link_timer.sv
// link_timer: loadable down-counter shared by the transmit guard and the
// remote-move timeout.
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   load_i          load load_val_i this cycle (takes priority over counting)
//   load_val_i      value to load; expire_o rises load_val_i cycles later
//   expire_o        count has reached zero (combinational decode of count)
module link_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Counts down and parks at zero until the next load.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == '0);

endmodule

// File: rtl/turn_controller.sv
// turn_controller: turn sequencer between the local game engine and the
// tranceiver link. Decides the local colour on the first move, alternates
// local and remote turns, guards the UART transmit window, and flags a remote
// timeout or an unexpected received move.
//   clock, reset                 clock, asynchronous active-low reset
//   local_move/valid/ready       local move from the engine
//   opp_move/valid/ready         opponent move to the engine
//   move_in, start_transmit      move and one-cycle send pulse to the tranceiver
//   move_out, end_receive, color received move, its strobe and its colour
//   my_color, my_turn            local colour, local-turn indicator
//   timeout, overrun             sticky fault flags
//   state_dbg                    current sequencer state
//
// Handshakes: a word moves on a rising edge where valid and ready are both
// high; valid never depends on ready, and the word is held stable while valid
// is high and ready is low.
module turn_controller
  import trax_link_pkg::*;
#(
  parameter int MOVE_W         = trax_link_pkg::MOVE_W,
  parameter int TX_GUARD       = 13100,
  parameter int TIMEOUT_CYCLES = 500000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [MOVE_W-1:0] local_move,
  input  logic              local_valid,
  output logic              local_ready,
  output logic [MOVE_W-1:0] opp_move,
  output logic              opp_valid,
  input  logic              opp_ready,
  output logic [MOVE_W-1:0] move_in,
  output logic              start_transmit,
  input  logic [MOVE_W-1:0] move_out,
  input  logic              end_receive,
  input  logic              color,
  output logic              my_color,
  output logic              my_turn,
  output logic              timeout,
  output logic              overrun,
  output link_state_t       state_dbg
);

  localparam int TW = timer_width(TX_GUARD, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] GUARD_LOAD   = TW'(TX_GUARD - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  link_state_t       state_q, state_d;
  logic [MOVE_W-1:0] move_in_q, move_in_d;
  logic [MOVE_W-1:0] opp_move_q, opp_move_d;
  logic [MOVE_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              my_color_q, my_color_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              start_tx_q, start_tx_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_expire;

  link_timer #(.W(TW)) u_timer (
    .clk_i      (clock),
    .rst_n_i    (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    move_in_d   = move_in_q;
    opp_move_d  = opp_move_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    my_color_d  = my_color_q;
    timeout_d   = timeout_q;
    overrun_d   = overrun_q;
    start_tx_d  = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = GUARD_LOAD;

    case (state_q)
      S_START: begin
        // A received move decides the colours, so it beats a local move
        // arriving in the same cycle (local_ready is dropped for that cycle).
        if (end_receive) begin
          opp_move_d = move_out;
          my_color_d = ~color;
          state_d    = S_DELIVER;
        end else if (local_valid) begin
          move_in_d  = local_move;
          my_color_d = WHITE;
          start_tx_d = 1'b1;
          tmr_load   = 1'b1;
          state_d    = S_GUARD;
        end
      end

      S_LOCAL: begin
        if (local_valid) begin
          move_in_d  = local_move;
          start_tx_d = 1'b1;
          tmr_load   = 1'b1;
          state_d    = S_GUARD;
        end
        if (end_receive) begin
          overrun_d = 1'b1;
        end
      end

      S_GUARD: begin
        if (tmr_expire) begin
          // Last guard cycle: a held move, or one arriving right now, goes
          // straight to the engine; otherwise start waiting for the opponent.
          hold_full_d = 1'b0;
          if (hold_full_q) begin
            opp_move_d = hold_q;
            state_d    = S_DELIVER;
            if (end_receive) begin
              overrun_d = 1'b1;
            end
          end else if (end_receive) begin
            opp_move_d = move_out;
            state_d    = S_DELIVER;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LOAD;
            state_d  = S_REMOTE;
          end
        end else if (end_receive) begin
          if (hold_full_q) begin
            overrun_d = 1'b1;
          end else begin
            hold_d      = move_out;
            hold_full_d = 1'b1;
          end
        end
      end

      S_REMOTE: begin
        // A move on the terminal count still counts as arrived in time.
        if (end_receive) begin
          opp_move_d = move_out;
          state_d    = S_DELIVER;
        end else if (tmr_expire) begin
          timeout_d = 1'b1;
          state_d   = S_FAULT;
        end
      end

      S_DELIVER: begin
        if (opp_ready) begin
          state_d = S_LOCAL;
        end
        if (end_receive) begin
          overrun_d = 1'b1;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_START;
      move_in_q   <= '0;
      opp_move_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      my_color_q  <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      start_tx_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      move_in_q   <= move_in_d;
      opp_move_q  <= opp_move_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      my_color_q  <= my_color_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
      start_tx_q  <= start_tx_d;
    end
  end

  assign local_ready    = ((state_q == S_START) && !end_receive) || (state_q == S_LOCAL);
  assign my_turn        = (state_q == S_LOCAL);
  assign opp_valid      = (state_q == S_DELIVER);
  assign move_in        = move_in_q;
  assign opp_move       = opp_move_q;
  assign start_transmit = start_tx_q;
  assign my_color       = my_color_q;
  assign timeout        = timeout_q;
  assign overrun        = overrun_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_turn_controller.sv
module tb_turn_controller;
  import trax_link_pkg::*;

  localparam int W        = 22;
  localparam int TX_GUARD = 8;
  localparam int TIMEOUT  = 100;

  logic          clock;
  logic          reset;
  logic [W-1:0]  local_move;
  logic          local_valid;
  logic          local_ready;
  logic [W-1:0]  opp_move;
  logic          opp_valid;
  logic          opp_ready;
  logic [W-1:0]  move_in;
  logic          start_transmit;
  logic [W-1:0]  move_out;
  logic          end_receive;
  logic          color;
  logic          my_color;
  logic          my_turn;
  logic          timeout;
  logic          overrun;
  link_state_t   state_dbg;

  int checks = 0;
  int errors = 0;

  turn_controller #(
    .MOVE_W         (W),
    .TX_GUARD       (TX_GUARD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .local_move     (local_move),
    .local_valid    (local_valid),
    .local_ready    (local_ready),
    .opp_move       (opp_move),
    .opp_valid      (opp_valid),
    .opp_ready      (opp_ready),
    .move_in        (move_in),
    .start_transmit (start_transmit),
    .move_out       (move_out),
    .end_receive    (end_receive),
    .color          (color),
    .my_color       (my_color),
    .my_turn        (my_turn),
    .timeout        (timeout),
    .overrun        (overrun),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Returns 1 time unit after a rising edge: inputs driven here are sampled
  // by the next edge, outputs read here reflect the edge just taken.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    local_move  = '0;
    local_valid = 1'b0;
    opp_ready   = 1'b0;
    move_out    = '0;
    end_receive = 1'b0;
    color       = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic test_reset();
    logic [W-1:0] mv;
    reset       = 1'b0;
    local_move  = '0;
    local_valid = 1'b0;
    opp_ready   = 1'b0;
    move_out    = '0;
    end_receive = 1'b0;
    color       = 1'b0;
    #3;
    checks++;
    if ({move_in, opp_move, my_color, timeout, overrun, opp_valid, start_transmit, my_turn} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got move_in=%h opp_move=%h col=%b to=%b ov=%b ov_v=%b st=%b turn=%b want all 0",
               move_in, opp_move, my_color, timeout, overrun, opp_valid, start_transmit, my_turn);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (local_ready !== 1'b1 || state_dbg !== S_START) begin
      errors++;
      $display("FAIL reset_start: got ready=%b state=%0d want ready=1 state=%0d", local_ready, state_dbg, S_START);
    end
    mv = '0;
    checks++;
    if (move_in !== mv) begin
      errors++;
      $display("FAIL reset_move_in_hold: got %h want %h", move_in, mv);
    end
  endtask

  task automatic test_local_first();
    int pulses;
    do_reset();
    local_move  = 22'h0ABCDE;
    local_valid = 1'b1;
    tick();
    local_valid = 1'b0;
    local_move  = W'($urandom);
    pulses = start_transmit ? 1 : 0;
    checks++;
    if (start_transmit !== 1'b1 || move_in !== 22'h0ABCDE || my_color !== 1'b0 || local_ready !== 1'b0) begin
      errors++;
      $display("FAIL local_tx: got st=%b move_in=%h col=%b ready=%b want 1 0abcde 0 0",
               start_transmit, move_in, my_color, local_ready);
    end
    for (int k = 1; k < TX_GUARD; k++) begin
      tick();
      if (start_transmit) pulses++;
    end
    checks++;
    if (state_dbg !== S_GUARD) begin
      errors++;
      $display("FAIL guard_len: got state=%0d want %0d one cycle before guard end", state_dbg, S_GUARD);
    end
    tick();
    checks++;
    if (state_dbg !== S_REMOTE) begin
      errors++;
      $display("FAIL remote_entry: got state=%0d want %0d", state_dbg, S_REMOTE);
    end
    checks++;
    if (pulses != 1 || move_in !== 22'h0ABCDE) begin
      errors++;
      $display("FAIL tx_single_pulse: got pulses=%0d move_in=%h want 1 0abcde", pulses, move_in);
    end
  endtask

  task automatic test_remote_first();
    do_reset();
    move_out    = 22'h155555;
    color       = 1'b0;
    end_receive = 1'b1;
    tick();
    end_receive = 1'b0;
    move_out    = W'($urandom);
    checks++;
    if (opp_valid !== 1'b1 || opp_move !== 22'h155555 || my_color !== 1'b1 || my_turn !== 1'b0) begin
      errors++;
      $display("FAIL remote_first: got v=%b opp=%h col=%b turn=%b want 1 155555 1 0",
               opp_valid, opp_move, my_color, my_turn);
    end
    opp_ready = 1'b1;
    tick();
    opp_ready = 1'b0;
    checks++;
    if (my_turn !== 1'b1 || opp_valid !== 1'b0 || local_ready !== 1'b1 || opp_move !== 22'h155555) begin
      errors++;
      $display("FAIL engine_handshake: got turn=%b v=%b ready=%b opp=%h want 1 0 1 155555",
               my_turn, opp_valid, local_ready, opp_move);
    end
  endtask

  task automatic test_collision();
    logic [W-1:0] r;
    int pulses;
    do_reset();
    r           = W'($urandom);
    local_move  = W'($urandom);
    local_valid = 1'b1;
    move_out    = r;
    color       = 1'b1;
    end_receive = 1'b1;
    #1;
    checks++;
    if (local_ready !== 1'b0) begin
      errors++;
      $display("FAIL collision_ready: got %b want 0", local_ready);
    end
    tick();
    end_receive = 1'b0;
    checks++;
    if (opp_valid !== 1'b1 || opp_move !== r || my_color !== 1'b0) begin
      errors++;
      $display("FAIL collision_rx: got v=%b opp=%h col=%b want 1 %h 0", opp_valid, opp_move, my_color, r);
    end
    pulses = start_transmit ? 1 : 0;
    for (int k = 0; k < TX_GUARD + 2; k++) begin
      tick();
      if (start_transmit) pulses++;
    end
    local_valid = 1'b0;
    checks++;
    if (pulses != 0 || move_in !== '0) begin
      errors++;
      $display("FAIL collision_no_tx: got pulses=%0d move_in=%h want 0 0", pulses, move_in);
    end
  endtask

  task automatic test_guard_hold();
    do_reset();
    local_move  = W'($urandom);
    local_valid = 1'b1;
    tick();
    local_valid = 1'b0;
    tick();
    tick();
    move_out    = 22'h000123;
    end_receive = 1'b1;
    tick();
    end_receive = 1'b0;
    move_out    = W'($urandom);
    repeat (TX_GUARD - 4) tick();
    checks++;
    if (opp_valid !== 1'b0 || state_dbg !== S_GUARD) begin
      errors++;
      $display("FAIL hold_early: got v=%b state=%0d want 0 %0d", opp_valid, state_dbg, S_GUARD);
    end
    tick();
    checks++;
    if (opp_valid !== 1'b1 || opp_move !== 22'h000123 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL hold_deliver: got v=%b opp=%h ov=%b want 1 000123 0", opp_valid, opp_move, overrun);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    local_move  = W'($urandom);
    local_valid = 1'b1;
    tick();
    local_valid = 1'b0;
    repeat (TX_GUARD) tick();
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b want 0 at cycle %0d of remote", timeout, TIMEOUT - 1);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || state_dbg !== S_FAULT) begin
      errors++;
      $display("FAIL timeout_set: got to=%b state=%0d want 1 %0d", timeout, state_dbg, S_FAULT);
    end
    move_out    = W'($urandom);
    end_receive = 1'b1;
    local_valid = 1'b1;
    tick();
    end_receive = 1'b0;
    tick();
    checks++;
    if (opp_valid !== 1'b0 || local_ready !== 1'b0 || opp_move !== '0 || timeout !== 1'b1 || start_transmit !== 1'b0) begin
      errors++;
      $display("FAIL fault_ignore: got v=%b ready=%b opp=%h to=%b st=%b want 0 0 0 1 0",
               opp_valid, local_ready, opp_move, timeout, start_transmit);
    end
    local_valid = 1'b0;
  endtask

  task automatic test_overrun_and_async_reset();
    logic [W-1:0] a;
    int pulses;
    do_reset();
    a           = W'($urandom);
    move_out    = a;
    color       = 1'($urandom_range(0, 1));
    end_receive = 1'b1;
    tick();
    move_out    = ~a;
    tick();
    end_receive = 1'b0;
    checks++;
    if (overrun !== 1'b1 || opp_move !== a || opp_valid !== 1'b1) begin
      errors++;
      $display("FAIL deliver_overrun: got ov=%b opp=%h v=%b want 1 %h 1", overrun, opp_move, opp_valid, a);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({move_in, opp_move, my_color, timeout, overrun, opp_valid, start_transmit, my_turn} !== '0) begin
      errors++;
      $display("FAIL async_reset_deliver: got opp=%h col=%b ov=%b v=%b want all 0", opp_move, my_color, overrun, opp_valid);
    end
    tick();
    reset = 1'b1;
    tick();
    // reset in the middle of a guard with a move held
    local_move  = W'($urandom);
    local_valid = 1'b1;
    tick();
    local_valid = 1'b0;
    move_out    = W'($urandom);
    end_receive = 1'b1;
    tick();
    end_receive = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (start_transmit !== 1'b0 || move_in !== '0 || state_dbg !== S_START) begin
      errors++;
      $display("FAIL async_reset_guard: got st=%b move_in=%h state=%0d want 0 0 %0d", start_transmit, move_in, state_dbg, S_START);
    end
    tick();
    reset  = 1'b1;
    pulses = 0;
    for (int k = 0; k < TX_GUARD + 3; k++) begin
      tick();
      if (start_transmit || opp_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || state_dbg !== S_START) begin
      errors++;
      $display("FAIL held_discarded: got activity=%0d state=%0d want 0 %0d", pulses, state_dbg, S_START);
    end
  endtask

  // Random game against a turn-level model: the engine and the opponent
  // alternate; every opponent move must reach the engine unchanged and in
  // order, colour is fixed by whoever moved first, overrun is set only by
  // receives that arrive while no reply is outstanding.
  task automatic test_random_game(input int rounds);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mv;
    logic [W-1:0] om;
    logic [W-1:0] exp;
    logic         exp_color;
    logic         exp_overrun;
    logic         first;
    logic         local_turn;
    logic         c;
    int           delay;
    int           n;
    do_reset();
    exp_color   = 1'b0;
    exp_overrun = 1'b0;
    first       = 1'b1;
    local_turn  = 1'($urandom_range(0, 1));
    for (int r = 0; r < rounds; r++) begin
      if (local_turn) begin
        if (!first && $urandom_range(0, 3) == 0) begin
          move_out    = W'($urandom);
          end_receive = 1'b1;
          tick();
          end_receive = 1'b0;
          exp_overrun = 1'b1;
        end
        repeat ($urandom_range(0, 3)) tick();
        mv          = W'($urandom);
        local_move  = mv;
        local_valid = 1'b1;
        #1;
        checks++;
        if (local_ready !== 1'b1) begin
          errors++;
          $display("FAIL rnd_ready r%0d: got %b want 1", r, local_ready);
        end
        tick();
        local_valid = 1'b0;
        if (first) exp_color = WHITE;
        first = 1'b0;
        checks++;
        if (start_transmit !== 1'b1 || move_in !== mv) begin
          errors++;
          $display("FAIL rnd_tx r%0d: got st=%b move_in=%h want 1 %h", r, start_transmit, move_in, mv);
        end
        delay = $urandom_range(1, TX_GUARD + 30);
        repeat (delay - 1) tick();
        om          = W'($urandom);
        move_out    = om;
        color       = ~exp_color;
        end_receive = 1'b1;
        tick();
        end_receive = 1'b0;
        exp_q.push_back(om);
      end else begin
        repeat ($urandom_range(0, 3)) tick();
        om          = W'($urandom);
        c           = 1'($urandom_range(0, 1));
        move_out    = om;
        color       = c;
        end_receive = 1'b1;
        tick();
        end_receive = 1'b0;
        if (first) exp_color = ~c;
        first = 1'b0;
        exp_q.push_back(om);
      end
      n = 0;
      while (opp_valid !== 1'b1 && n < TX_GUARD + 10) begin
        tick();
        n++;
      end
      exp = exp_q.pop_front();
      checks++;
      if (opp_valid !== 1'b1 || opp_move !== exp || my_color !== exp_color) begin
        errors++;
        $display("FAIL rnd_deliver r%0d: got v=%b opp=%h col=%b want 1 %h %b", r, opp_valid, opp_move, my_color, exp, exp_color);
      end
      if ($urandom_range(0, 3) == 0) begin
        move_out    = W'($urandom);
        end_receive = 1'b1;
        tick();
        end_receive = 1'b0;
        exp_overrun = 1'b1;
      end
      repeat ($urandom_range(0, 2)) tick();
      opp_ready = 1'b1;
      tick();
      opp_ready = 1'b0;
      checks++;
      if (my_turn !== 1'b1 || opp_valid !== 1'b0 || opp_move !== exp || overrun !== exp_overrun || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rnd_turn r%0d: got turn=%b v=%b opp=%h ov=%b to=%b want 1 0 %h %b 0",
                 r, my_turn, opp_valid, opp_move, overrun, timeout, exp, exp_overrun);
      end
      local_turn = 1'b1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_local_first();
    test_remote_first();
    test_collision();
    test_guard_hold();
    test_timeout();
    test_overrun_and_async_reset();
    for (int g = 0; g < 4; g++) begin
      test_random_game(6);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/turn_controller.md
# turn_controller

Game-side turn sequencer sitting directly downstream of the `tranceiver` link block and upstream of the local game engine. It accepts local moves from the engine and drives `move_in`/`start_transmit`, and captures opponent moves on `end_receive`. It presents opponent moves to the engine over a valid/ready handshake. It also decides the local colour, enforces strict turn alternation, and flags a remote timeout or a protocol overrun.

## Interface
Parameters:
- `MOVE_W`, 22: move word width; must match the `tranceiver` move ports.
- `TX_GUARD`, 13100: cycles reserved for a 3-byte UART transmit after `start_transmit`; must be ≥ 1.
- `TIMEOUT_CYCLES`, 500000000: maximum wait for an opponent move in REMOTE; must be ≥ 1.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `local_move`  in  MOVE_W  move from the engine.
- `local_valid`  in  1  `local_move` is valid.
- `local_ready`  out  1  controller accepts `local_move`.
- `opp_move`  out  MOVE_W  opponent move to the engine.
- `opp_valid`  out  1  `opp_move` is valid.
- `opp_ready`  in  1  engine accepts `opp_move`.
- `move_in`  out  MOVE_W  to `tranceiver.move_in`.
- `start_transmit`  out  1  to `tranceiver.start_transmit`; one-cycle pulse.
- `move_out`  in  MOVE_W  from `tranceiver.move_out`.
- `end_receive`  in  1  from `tranceiver`; one-cycle pulse when `move_out` is valid.
- `color`  in  1  from `tranceiver`; colour carried by the received move.
- `my_color`  out  1  local colour (0 = first mover).
- `my_turn`  out  1  high in LOCAL.
- `timeout`  out  1  sticky; set on remote timeout.
- `overrun`  out  1  sticky; set on an unexpected `end_receive`.

## Operation
- States: START, LOCAL, GUARD, REMOTE, DELIVER, FAULT.
- START (`local_ready`=1):
  - `local_valid` → latch the move into `move_in`, set `my_color`=0, go to GUARD.
  - `end_receive` → latch `move_out` into `opp_move`, set `my_color`=~`color`, go to DELIVER.
  - Both in the same cycle → receive wins. The local move is not accepted because `local_ready` is forced to 0 in that cycle.
- LOCAL (`local_ready`=1, `my_turn`=1): `local_valid` → latch into `move_in`, go to GUARD.
- GUARD:
  - `start_transmit`=1 in the first GUARD cycle only.
  - After `TX_GUARD` cycles in GUARD → REMOTE, or → DELIVER if the hold register is full.
  - `end_receive` in GUARD → capture `move_out` into a one-entry hold register. A second one in GUARD is dropped and sets `overrun`.
- REMOTE: timer counts from 0.
  - `end_receive` → latch into `opp_move`, go to DELIVER.
  - Timer reaching `TIMEOUT_CYCLES`-1 without `end_receive` → FAULT.
  - `end_receive` on the terminal cycle wins; no timeout.
- DELIVER: `opp_valid`=1 and `opp_move` is held stable. `opp_valid && opp_ready` → LOCAL.
- `end_receive` in LOCAL or DELIVER → ignored, `overrun` set. It is also ignored in FAULT.
- FAULT: `timeout`=1. All handshakes are deasserted; the block stays here until reset.
- `move_in` changes only on acceptance of a local move. `opp_move` changes only on capture.

## Timing
- Reset values: state START; `move_in`, `opp_move`, `my_color`, `timeout`, `overrun`, `opp_valid`, `start_transmit`, `my_turn` all 0. `local_ready`=1 once START is entered after reset release.
- Local accept at edge N → `start_transmit` high in cycle N+1 with `move_in` already stable → REMOTE at edge N+`TX_GUARD`.
- `end_receive` at edge N in START or REMOTE → `opp_valid` high in cycle N+1.
- Engine handshake at edge N → `my_turn`=1 in cycle N+1.
- All outputs are registered except `local_ready`, `my_turn` and `opp_valid`, which decode the state register.
- Reset asserted mid-GUARD or mid-DELIVER → immediate return to reset values. Any in-flight transmit pulse and any held move are discarded.

## Structure
- Package `trax_link_pkg`: `MOVE_W`, the state enum `link_state_t`, and colour constants `WHITE`=0 and `BLACK`=1. It is shared with `tranceiver_tx` and `transeiver_rx`.
- One sub-module, `link_timer`: a loadable down-counter with an `expire` output, width $clog2(max(`TX_GUARD`, `TIMEOUT_CYCLES`)). A single instance serves both GUARD and REMOTE.

## Test plan
- Reset, then `local_valid` with move 22'h0ABCDE → `start_transmit` single pulse with `move_in`=22'h0ABCDE; `my_color`=0; REMOTE after `TX_GUARD` cycles.
- Reset, then `end_receive` with `move_out`=22'h155555 and `color`=0 → `my_color`=1, `opp_valid` with 22'h155555; `opp_ready` → `my_turn`=1.
- `local_valid` and `end_receive` in the same START cycle → receive path taken; `start_transmit` never pulses; `local_ready`=0 in that cycle.
- `end_receive` mid-GUARD with 22'h000123 → DELIVER directly at guard end; `opp_move`=22'h000123; `overrun`=0.
- REMOTE with no receive (`TIMEOUT_CYCLES`=100) → `timeout`=1 exactly 100 cycles after REMOTE entry; subsequent `end_receive` ignored.
- `end_receive` in DELIVER while `opp_ready`=0 → `overrun`=1 and `opp_move` unchanged. Reset asserted mid-DELIVER → all outputs return to 0 asynchronously.
